regfile_be_clr: RTL

Parametrised successor of the team's 32x32 two-read/one-write register file.
- Generalised in data width and depth.
- Adds per-byte write enables, an optional hardwired-zero register 0, and optional write-to-read bypass.
- Adds a multi-cycle sweep-clear engine with a Busy handshake.
- Sits between datapath/debug logic (switches, LED display, CPU decode) and the register storage.

---
 rtl/regfile_pkg.sv | 36 +++
 rtl/regfile_clear_fsm.sv | 63 ++++++
 rtl/regfile_be_clr.sv | 105 ++++++++++
 3 files changed

// File: rtl/regfile_pkg.sv
// -----------------------------------------------------------------------------
// regfile_pkg
// Shared types and helpers for the byte-enable register file.
//   state_t  : sweep-clear FSM states (IDLE, CLEAR)
//   be_merge : byte-merge of a stored word with new write data under byte
//              enables; used by both the storage write path and the bypass
//              path so the two can never disagree.
// The helper works on a fixed maximum width; callers zero-extend into it and
// truncate the result back to their own DATA_W.
// -----------------------------------------------------------------------------
package regfile_pkg;

    typedef enum logic {
        IDLE  = 1'b0,
        CLEAR = 1'b1
    } state_t;

    localparam int MAX_DATA_W = 256;
    localparam int MAX_BE_W   = MAX_DATA_W / 8;

    function automatic logic [MAX_DATA_W-1:0] be_merge(
        input logic [MAX_DATA_W-1:0] old_word,
        input logic [MAX_DATA_W-1:0] new_word,
        input logic [MAX_BE_W-1:0]   be
    );
        logic [MAX_DATA_W-1:0] merged;
        merged = old_word;
        for (int k = 0; k < MAX_BE_W; k++) begin
            if (be[k]) begin
                merged[8*k +: 8] = new_word[8*k +: 8];
            end
        end
        return merged;
    endfunction

endpackage

// File: rtl/regfile_clear_fsm.sv
// -----------------------------------------------------------------------------
// regfile_clear_fsm
// Sweep-clear sequencer. A Clear_Req seen in IDLE starts a walk over every
// entry, zeroing one per clock, with Busy high for exactly DEPTH cycles.
// Ports:
//   clk       : rising-edge clock
//   Reset     : asynchronous active-low reset
//   Clear_Req : start a sweep (ignored while a sweep is running)
//   Busy      : registered, high while the sweep runs
//   clr_en    : storage should zero entry clr_addr on this edge
//   clr_addr  : entry being cleared this cycle
// -----------------------------------------------------------------------------
module regfile_clear_fsm
    import regfile_pkg::*;
#(
    parameter int ADDR_W = 5
) (
    input  logic              clk,
    input  logic              Reset,
    input  logic              Clear_Req,
    output logic              Busy,
    output logic              clr_en,
    output logic [ADDR_W-1:0] clr_addr
);

    state_t            state;
    logic [ADDR_W-1:0] counter;

    always_ff @(posedge clk or negedge Reset) begin
        if (!Reset) begin
            state   <= IDLE;
            counter <= '0;
            Busy    <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (Clear_Req) begin
                        state   <= CLEAR;
                        counter <= '0;
                        Busy    <= 1'b1;
                    end
                end
                CLEAR: begin
                    // Counter wraps back to 0 on the last entry, leaving it
                    // ready for the next sweep.
                    counter <= counter + 1'b1;
                    if (counter == '1) begin
                        state <= IDLE;
                        Busy  <= 1'b0;
                    end
                end
                default: begin
                    state <= IDLE;
                    Busy  <= 1'b0;
                end
            endcase
        end
    end

    assign clr_en   = (state == CLEAR);
    assign clr_addr = counter;

endmodule

// File: rtl/regfile_be_clr.sv
// -----------------------------------------------------------------------------
// regfile_be_clr
// Two-read / one-write register file with per-byte write enables, optional
// hardwired-zero entry 0, optional same-cycle write-to-read bypass, and a
// multi-cycle sweep-clear engine.
// Ports:
//   clk                  : rising-edge clock
//   Reset                : asynchronous active-low reset (clears all entries)
//   R_Addr_A / R_Addr_B  : read addresses
//   R_Data_A / R_Data_B  : combinational read data
//   W_Addr, W_Data, W_BE : write address, data, byte enables
//   Write_Reg            : write strobe
//   Clear_Req            : request a sweep-clear of every entry
//   Busy                 : registered, high while the sweep runs
//   Write_Rej            : a write strobe arrived while Busy and was dropped
// -----------------------------------------------------------------------------
module regfile_be_clr
    import regfile_pkg::*;
#(
    parameter int DATA_W   = 32,
    parameter int ADDR_W   = 5,
    parameter int ZERO_REG = 1,
    parameter int BYPASS   = 1
) (
    input  logic                clk,
    input  logic                Reset,
    input  logic [ADDR_W-1:0]   R_Addr_A,
    input  logic [ADDR_W-1:0]   R_Addr_B,
    output logic [DATA_W-1:0]   R_Data_A,
    output logic [DATA_W-1:0]   R_Data_B,
    input  logic [ADDR_W-1:0]   W_Addr,
    input  logic [DATA_W-1:0]   W_Data,
    input  logic [DATA_W/8-1:0] W_BE,
    input  logic                Write_Reg,
    input  logic                Clear_Req,
    output logic                Busy,
    output logic                Write_Rej
);

    localparam int DEPTH = 2 ** ADDR_W;

    logic [DATA_W-1:0] mem [DEPTH];

    logic              clr_en;
    logic [ADDR_W-1:0] clr_addr;
    logic              wr_to_zero;
    logic              wr_ok;
    logic [DATA_W-1:0] merged_w;

    regfile_clear_fsm #(
        .ADDR_W (ADDR_W)
    ) u_clear_fsm (
        .clk       (clk),
        .Reset     (Reset),
        .Clear_Req (Clear_Req),
        .Busy      (Busy),
        .clr_en    (clr_en),
        .clr_addr  (clr_addr)
    );

    assign wr_to_zero = (ZERO_REG != 0) && (W_Addr == '0);
    assign wr_ok      = Write_Reg && !Busy && !wr_to_zero;
    assign Write_Rej  = Write_Reg && Busy;

    // Merged word for the addressed entry; the same value feeds storage and
    // the bypass path.
    assign merged_w = DATA_W'(be_merge(MAX_DATA_W'(mem[W_Addr]),
                                       MAX_DATA_W'(W_Data),
                                       MAX_BE_W'(W_BE)));

    always_ff @(posedge clk or negedge Reset) begin
        if (!Reset) begin
            for (int i = 0; i < DEPTH; i++) begin
                mem[i] <= '0;
            end
        end else if (clr_en) begin
            mem[clr_addr] <= '0;
        end else if (wr_ok) begin
            mem[W_Addr] <= merged_w;
        end
    end

    // Entry 0 is never written when hardwired, but the read mux forces 0 as
    // well so the bypass cannot leak a value there.
    always_comb begin
        R_Data_A = mem[R_Addr_A];
        if ((BYPASS != 0) && wr_ok && (W_Addr == R_Addr_A)) begin
            R_Data_A = merged_w;
        end
        if ((ZERO_REG != 0) && (R_Addr_A == '0)) begin
            R_Data_A = '0;
        end
    end

    always_comb begin
        R_Data_B = mem[R_Addr_B];
        if ((BYPASS != 0) && wr_ok && (W_Addr == R_Addr_B)) begin
            R_Data_B = merged_w;
        end
        if ((ZERO_REG != 0) && (R_Addr_B == '0)) begin
            R_Data_B = '0;
        end
    end

endmodule
